// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared cache types and constants for the instruction cache.
package cpu_types_pkg;
  localparam int ICACHE_FRAMES = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_FRAMES);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame;
  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache_frame_array.sv
// icache_frame_array: direct-mapped frame storage with clearable valid bits,
// one combinational read port and one write port.
module icache_frame_array #(
  parameter int NFRAMES = 16,
  parameter int IDX_W = $clog2(NFRAMES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);
  logic [NFRAMES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_arr [NFRAMES];
  logic [31:0] data_arr [NFRAMES];
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end
  // Tag/data are not reset; a reset edge must not write even if a fill was due.
  always_ff @(posedge CLK) begin
    valid_q <= nRST ? valid_d : '0;
    if (nRST && wr_en) begin
      tag_arr[wr_idx] <= wr_tag;
      data_arr[wr_idx] <= wr_data;
    end
  end
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag = tag_arr[rd_idx];
  assign rd_data = data_arr[rd_idx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache; misses fetch one word
// over the iREN/iwait handshake while ihit stays low.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = ICACHE_FRAMES
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);
  localparam int IDX_W = $clog2(NFRAMES);
  localparam int TAG_W = 30 - IDX_W;
  icache_state_t state_q, state_d;
  logic [29:0] miss_q, miss_d;
  logic rd_valid, wr_en, unused_bytoff;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0] rd_data;
  assign unused_bytoff = ^imemaddr[1:0];
  icache_frame_array #(.NFRAMES(NFRAMES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
    .CLK(CLK),
    .nRST(nRST),
    .rd_idx(imemaddr[1+IDX_W:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .wr_en(wr_en),
    .wr_idx(miss_q[IDX_W-1:0]),
    .wr_tag(miss_q[29:IDX_W]),
    .wr_data(iload)
  );
  always_comb begin
    ihit = imemREN & rd_valid & (rd_tag == imemaddr[31:2+IDX_W]);
    imemload = ihit ? rd_data : 32'h0;
    iREN = (state_q == FETCH);
    iaddr = iREN ? {miss_q, 2'b00} : 32'h0;
    wr_en = iREN & ~iwait;
    state_d = state_q;
    miss_d = miss_q;
    if (state_q == IDLE && imemREN && !ihit) begin
      state_d = FETCH;
      miss_d = imemaddr[31:2];
    end
    if (wr_en) state_d = IDLE;
  end
  always_ff @(posedge CLK) begin
    state_q <= nRST ? state_d : IDLE;
    miss_q <= nRST ? miss_d : '0;
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's instruction-fetch port and the memory controller.
- Consumes the datapath's imemREN/imemaddr and returns ihit/imemload.
- On a miss, fetches one word from memory over the iREN/iaddr/iload/iwait handshake and fills the frame.
- Stalls fetch by holding ihit low until the word is resident.

Parameters:
- NFRAMES, 16, number of one-word frames; power of two; index width IDX_W = log2(NFRAMES).
- TAG_W, 30 - IDX_W, tag width (address bits [31:2+IDX_W]).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  requested word valid this cycle
- imemload  out  32  instruction word; 0 when ihit=0
- iREN  out  1  memory read request
- iaddr  out  32  memory word address, bits [1:0]=00
- iload  in  32  memory read data
- iwait  in  1  memory busy; data valid on a cycle with iREN=1 and iwait=0

Behaviour:
- Reset and clocking:
  - One clock CLK; reset nRST is synchronous, active-low. Sampled only on the rising edge of CLK.
  - Reset clears all valid bits and forces state to IDLE.
  - Tag and data arrays are not reset.
  - After reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- Address split:
  - tag = imemaddr[31:2+IDX_W]
  - idx = imemaddr[1+IDX_W:2]
- Hit (combinational, zero latency):
  - ihit = imemREN & valid[idx] & (tag_arr[idx]==tag).
  - imemload = data_arr[idx] when ihit, else 0.
  - Hits are returned in any state.
- FSM states: IDLE, FETCH.
  - IDLE:
    - If imemREN and not hit: latch miss_addr = {imemaddr[31:2],2'b00}, go to FETCH next cycle.
    - Otherwise stay in IDLE. iREN=0.
  - FETCH:
    - iREN=1, iaddr=miss_addr; iaddr is held stable for the whole request.
    - On a cycle with iwait=0, at the next edge: data_arr[miss idx]<=iload, tag_arr<=miss tag, valid<=1. Go to IDLE.
    - While iwait=1, stay in FETCH.
- Miss latency:
  - Miss detected in cycle 0, iREN asserted from cycle 1.
  - With memory returning data after N wait cycles, the fill is written at the end of cycle 1+N and ihit rises in cycle 2+N.
  - No same-cycle forwarding of iload to imemload.
- imemaddr change during FETCH:
  - The fill completes for miss_addr regardless.
  - ihit tracks the current address only; a new miss is taken from IDLE after return.
- imemREN low: no hit and no miss initiation; an in-flight FETCH still completes.
- Fill to a valid frame overwrites the old tag/data (direct-mapped replacement).
- Reset asserted mid-FETCH:
  - Request abandoned; iREN=0 from the next cycle.
  - No array write occurs on the reset edge.
  - All frames invalid afterward.
- Simultaneous fill and hit lookup on the same index: lookup sees old contents in that cycle, new contents from the next.
- There is no write path. Self-modifying code is unsupported. Consistency with dcache is not handled by this block.

Decomposition:
- cpu_types_pkg gains:
  - icachef_t packed struct {tag, idx, bytoff} parameterised by the default widths.
  - icache_frame typedef {valid, tag, data}.
  - ICACHE_FRAMES constant.
  - icache_state_t enum {IDLE, FETCH}.
- One natural sub-module: icache_frame_array. It holds the frame storage and valid bits, with synchronous clear, one combinational read port and one write port.
- The FSM and handshake logic stay in icache.

Test Plan:
1. Reset then fetch 0x00000000 with iload=0x3C010001, iwait=1 for 2 cycles → iREN=1, iaddr=0x0; ihit=0 until cycle 4; then ihit=1, imemload=0x3C010001, iREN=0.
2. Refetch 0x00000000 after test 1 → ihit=1 same cycle, iREN stays 0.
3. Fetch 0x00000040, which shares idx 0 with 0x0 (tag differs), with iload=0xDEADBEEF → miss and fill; then 0x0 misses again, showing eviction.
4. Miss in flight on 0x00000008, imemaddr switched to 0x00000004 (resident) → ihit=1 for 0x4 during FETCH; iaddr stays 0x8; fill completes; 0x8 then hits.
5. nRST low during FETCH with iwait=1 → next cycle iREN=0, ihit=0 for a previously resident address; no array write.
6. imemREN=0 with imemaddr=0x0000000C uncached → ihit=0, iREN stays 0 for 5 cycles.
